// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmitter state encodings, default bit timing
// and frame-level line constants. The matching receiver uses them too.
package uart_tx_pkg;

  // 50 MHz system clock divided down to 115200 baud.
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
  localparam int UART_DATA_BITS            = 8;

  // Line levels for the frame delimiters; the idle line equals the stop level.
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// CLR_VALUE lets the receiver restart mid-bit (half-bit offset); the
// transmitter restarts from 0.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CLR_VALUE    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLR_CNT  = CW'(CLR_VALUE);

  logic [CW-1:0] cnt;

  // Free-running bit counter, restarted whenever the owner changes state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CLR_CNT;
    end else if (cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends one 8N1 frame per rising edge of uart_transmit and
// reports idle/complete on uart_txd_done for CPU polling.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit (frame becomes 11 bit periods).
// Handshake: uart_transmit is a level request; a frame is accepted only on
// its 0->1 edge while idle. uart_txd_done is 1 whenever a new request would
// be accepted and drops to 0 the cycle after acceptance. Edges seen while
// busy are dropped, not queued.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_transmit,
  input  logic [DATA_BITS-1:0] uart_txd_data,
  output logic                 uart_txd_done,
  output logic                 uart_txd,
  output logic [2:0]           state_dbg
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 trans_q;
  logic                 start;
  logic                 bit_end;
  logic                 baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign start    = uart_transmit & ~trans_q & (state_q == UART_TX_IDLE);
  assign baud_clr = (state_d != state_q);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CLR_VALUE    (0)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  // State, shifter and registered line/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UART_TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= UART_STOP_BIT;
      done_q    <= 1'b1;
      trans_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      trans_q   <= uart_transmit;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next state plus the line level for that state, so uart_txd is registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      UART_TX_IDLE: begin
        if (start) begin
          shift_d   = uart_txd_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^uart_txd_data;
`endif
          state_d   = UART_TX_START;
        end
      end
      UART_TX_START: begin
        if (bit_end) state_d = UART_TX_DATA;
      end
      UART_TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = UART_TX_PARITY;
`else
            state_d   = UART_TX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: begin
        if (bit_end) state_d = UART_TX_STOP;
      end
`endif
      UART_TX_STOP: begin
        if (bit_end) state_d = UART_TX_IDLE;
      end
      default: state_d = UART_TX_IDLE;
    endcase

    txd_d = UART_STOP_BIT;
    case (state_d)
      UART_TX_START:  txd_d = UART_START_BIT;
      UART_TX_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: txd_d = parity_d;
`endif
      default:        txd_d = UART_STOP_BIT;
    endcase

    done_d = (state_d == UART_TX_IDLE);
  end

  assign uart_txd      = txd_q;
  assign uart_txd_done = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT=4. Stimulus pushes the expected
// {parity, data} into exp_q; an independent line monitor decodes every frame
// from uart_txd and compares it against the head of the queue.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int N = FRAME_BITS * C;

  logic       clk;
  logic       rst;
  logic       uart_transmit;
  logic [7:0] uart_txd_data;
  logic       uart_txd_done;
  logic       uart_txd;
  logic [2:0] state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [8:0] exp_q[$];

  uart_tx #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_transmit (uart_transmit),
    .uart_txd_data (uart_txd_data),
    .uart_txd_done (uart_txd_done),
    .uart_txd      (uart_txd),
    .state_dbg     (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: captures one frame sample per cycle from the start bit.
  task automatic collect_frame();
    logic       smp [N];
    int         done_low  = 0;
    int         shape_err = 0;
    bit         aborted   = 0;
    logic [7:0] data;
    logic [8:0] exp;
    smp[0] = uart_txd;
    if (uart_txd_done === 1'b0) done_low++;
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        aborted = 1;
        break;
      end
      smp[k] = uart_txd;
      if (uart_txd_done === 1'b0) done_low++;
    end
    if (aborted) return;
    @(negedge clk);
    for (int k = 0; k < N; k++)
      if (smp[k] !== smp[(k / C) * C + C / 2]) shape_err++;
    for (int j = 0; j < 8; j++) data[j] = smp[(j + 1) * C + C / 2];
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", data);
      return;
    end
    exp = exp_q.pop_front();
    check("frame_data", data, exp[7:0]);
    check("start_bit", smp[C / 2], 1'b0);
`ifdef UART_TX_PARITY_EN
    check("parity_bit", smp[9 * C + C / 2], exp[8]);
`endif
    check("stop_bit", smp[(FRAME_BITS - 1) * C + C / 2], 1'b1);
    check("bit_timing", shape_err, 0);
    check("done_low_cycles", done_low, N);
    check("done_after_frame", uart_txd_done, 1'b1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_txd === 1'b0) collect_frame();
    end
  end

  // Driver tasks.
  task automatic send(input logic [7:0] d, input logic par, input bit expect_frame);
    uart_transmit = 1'b0;
    uart_txd_data = d;
    @(posedge clk);
    #1;
    if (expect_frame) exp_q.push_back({par, d});
    uart_transmit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("start_latency_txd", uart_txd, 1'b0);
    check("start_latency_done", uart_txd_done, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (uart_txd_done !== 1'b1 && cyc < 2 * N + 20) begin
      @(negedge clk);
      cyc++;
    end
    check(name, uart_txd_done, 1'b1);
  endtask

  // Directed sequence.
  initial begin : stim
    int errs;
    rst           = 1'b1;
    uart_transmit = 1'b0;
    uart_txd_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_txd", uart_txd, 1'b1);
    check("reset_done", uart_txd_done, 1'b1);
    check("reset_state", state_dbg, UART_TX_IDLE);
    @(posedge clk);
    #1 rst = 1'b0;

    // 0xA5, then keep the request level high: no retransmission.
    send(8'hA5, 1'b0, 1'b1);
    wait_done("a5_done_timeout");
    errs = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_txd_done !== 1'b1) errs++;
    end
    check("hold_high_no_retx", errs, 0);

    // 0x3C with a second rising edge mid-frame.
    send(8'h3C, 1'b0, 1'b1);
    repeat (14) @(posedge clk);
    #1 uart_transmit = 1'b0;
    @(posedge clk);
    #1 uart_transmit = 1'b1;
    wait_done("3c_done_timeout");
    errs = 0;
    repeat (N + 10) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) errs++;
    end
    check("no_second_frame", errs, 0);

    // Data changes after the start cycle must not reach the line.
    send(8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1 uart_txd_data = 8'hFF;
    wait_done("00_done_timeout");

    // Reset mid-frame aborts; the next frame is complete and correct.
    send(8'h55, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_txd", uart_txd, 1'b1);
    check("abort_done", uart_txd_done, 1'b1);
    check("abort_state", state_dbg, UART_TX_IDLE);
    send(8'h96, 1'b0, 1'b1);
    wait_done("96_done_timeout");

    // Parity cases: 0x07 has three ones, 0x03 has two.
    send(8'h07, 1'b1, 1'b1);
    wait_done("07_done_timeout");
    send(8'h03, 1'b0, 1'b1);
    wait_done("03_done_timeout");

    uart_transmit = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
